sreg_tx_serializer: RTL
=======================

Name: sreg_tx_serializer

Overview:
Downstream stage of the 42-bit shift-register controller. Accepts one parallel word per valid/ready handshake and emits it on a 2-bit lane, LSB pair first, one pair per sclk, framed by a strobe. This is the same right-shift-by-2 order used by the controller. It ends each frame with a one-cycle done pulse and an optional programmable idle gap before accepting the next word.

Parameters:
WORD_W, 42, word width in bits; must be a multiple of LANE_W, otherwise elaboration fails.
LANE_W, 2, bits emitted per clock.
GAP_CYCLES, 0, extra idle cycles after each frame (0..15).

Ports:
sclk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
word_valid  input  1  upstream word available.
word_data  input  WORD_W  word to serialize; sampled only on handshake.
word_ready  output  1  block can accept a word; high only in IDLE, combinational from state.
flush  input  1  synchronous abort of the current frame.
sdo  output  LANE_W  serial data lane, registered.
sframe  output  1  high while sdo carries a valid beat, registered.
busy  output  1  high in any state except IDLE, combinational from state.
done  output  1  one-cycle pulse after the last beat of a completed frame, registered.

Behaviour:
- Reset (asynchronous, rst_n low): state goes to IDLE. sdo=0, sframe=0, done=0. Shift register and counters go to 0. Consequently word_ready=1 and busy=0. An in-flight frame is discarded; sframe drops immediately, with no done pulse.
- BEATS = WORD_W/LANE_W (21 by default). beat_cnt is $clog2(BEATS) bits wide.
- States are IDLE, SHIFT and GAP.
- IDLE:
  - Handshake occurs at the edge where word_valid && word_ready.
  - At that edge: sdo <= word_data[LANE_W-1:0], shreg <= word_data >> LANE_W, sframe <= 1, beat_cnt <= 0, state <= SHIFT.
  - word_valid is ignored outside IDLE. Upstream must hold word_data stable only while valid && !ready.
- SHIFT:
  - While beat_cnt < BEATS-1, on each edge: sdo <= shreg[LANE_W-1:0], shreg >>= LANE_W, beat_cnt++.
  - After handshake edge N, sdo holds word_data[2k+1:2k] after edge N+k, for k=0..20.
  - At the edge where beat_cnt == BEATS-1 (edge N+21):
    - sframe <= 0, sdo <= 0, done <= 1.
    - If GAP_CYCLES > 0, state <= GAP with gap_cnt loaded to GAP_CYCLES-1. Otherwise state <= IDLE.
- GAP: sframe=0 and sdo=0. gap_cnt decrements each cycle; the state moves to IDLE at the edge where gap_cnt == 0.
- done is high for exactly one cycle, the cycle after edge N+21. It is cleared on every other edge.
- Throughput:
  - The next handshake is possible no earlier than edge N+22+GAP_CYCLES.
  - sframe is low for at least 1+GAP_CYCLES cycles between frames.
- flush:
  - In SHIFT or GAP: at the next edge, state <= IDLE, sframe <= 0, sdo <= 0, no done pulse, counters cleared.
  - In IDLE: flush has priority over the handshake; the word is not accepted.
  - A flush asserted at the last-beat edge wins, so done is not pulsed.
- sdo is 0 whenever sframe is 0.

Decomposition:
- Shared package sreg_pkg:
  - SREG_WORD_W = 42 and SREG_LANE_W = 2 constants.
  - Typedef ser_state_t {IDLE, SHIFT, GAP}.
  - The same package holds the controller's 42-bit word typedef.
- Single module; no sub-module. The gap counter and beat counter are plain registers inside the block.

Test Plan:
- Single frame: word_data=42'h1B with valid held → sdo sequence 2'b11, 2'b10, 2'b01, then 18× 2'b00. sframe is high for exactly 21 cycles, and done pulses on cycle 22.
- Full pattern: word_data=42'h2AA_AAAA_AAAA → all 21 beats 2'b10. Then word_data=42'h3FF_FFFF_FFFF → all beats 2'b11. sframe goes low for exactly 1 cycle between frames (GAP_CYCLES=0, valid held high).
- Gap: GAP_CYCLES=3 with back-to-back valid → sframe is low for 4 cycles between frames. word_ready rises exactly 3 cycles after done.
- Flush mid-frame: flush pulsed at beat 10 → sframe=0 at the next edge, done never asserts, word_ready=1 one cycle later. The next word 42'h5 serializes correctly as 2'b01, 2'b01, then zeros.
- Async reset: rst_n asserted at beat 7, between clock edges → sframe, sdo and done go to 0 immediately, and word_ready=1 without a clock edge. After release, a new frame is accepted normally.
- Backpressure: word_valid asserted during SHIFT → word_ready stays 0 and no capture occurs. The word is accepted on the first IDLE cycle, and its beat 0 matches that word's bits [1:0].

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared types and constants for the 42-bit shift-register controller and its
// downstream serializer.
package sreg_pkg;

  localparam int SREG_WORD_W = 42;
  localparam int SREG_LANE_W = 2;

  typedef logic [SREG_WORD_W-1:0] sreg_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  function automatic int ser_beats(input int word_w, input int lane_w);
    return word_w / lane_w;
  endfunction

endpackage

// File: rtl/sreg_tx_serializer.sv
// Serializes one parallel word per valid/ready handshake onto a LANE_W-bit lane,
// LSB pair first, framed by sframe and closed by a one-cycle done pulse.
module sreg_tx_serializer
  import sreg_pkg::*;
#(
  parameter int WORD_W     = SREG_WORD_W,
  parameter int LANE_W     = SREG_LANE_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              flush,
  output logic [LANE_W-1:0] sdo,
  output logic              sframe,
  output logic              busy,
  output logic              done
);

  localparam int BEATS  = ser_beats(WORD_W, LANE_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W  = 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  generate
    if ((WORD_W % LANE_W) != 0) begin : g_bad_word_w
      $error("sreg_tx_serializer: WORD_W must be a multiple of LANE_W");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_bad_gap
      $error("sreg_tx_serializer: GAP_CYCLES must be within 0..15");
    end
  endgenerate

  ser_state_t        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [BEAT_W-1:0] r_beat;
  logic [GAP_W-1:0]  r_gap;
  logic [LANE_W-1:0] r_sdo;
  logic              r_sframe;
  logic              r_done;

  ser_state_t        w_state_nxt;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic [LANE_W-1:0] w_sdo_nxt;
  logic              w_sframe_nxt;
  logic              w_done_nxt;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_beat   <= '0;
      r_gap    <= '0;
      r_sdo    <= '0;
      r_sframe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_beat   <= w_beat_nxt;
      r_gap    <= w_gap_nxt;
      r_sdo    <= w_sdo_nxt;
      r_sframe <= w_sframe_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // sdo/sframe/done default low so every non-beat cycle is quiet on the lane.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_beat_nxt   = r_beat;
    w_gap_nxt    = r_gap;
    w_sdo_nxt    = '0;
    w_sframe_nxt = 1'b0;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (flush) begin
          w_shreg_nxt = '0;
          w_beat_nxt  = '0;
          w_gap_nxt   = '0;
        end else if (word_valid) begin
          w_sdo_nxt    = word_data[LANE_W-1:0];
          w_shreg_nxt  = word_data >> LANE_W;
          w_sframe_nxt = 1'b1;
          w_beat_nxt   = '0;
          w_state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        if (flush) begin
          w_state_nxt = IDLE;
          w_shreg_nxt = '0;
          w_beat_nxt  = '0;
          w_gap_nxt   = '0;
        end else if (r_beat == LAST_BEAT) begin
          w_done_nxt  = 1'b1;
          w_shreg_nxt = '0;
          w_beat_nxt  = '0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_gap_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_sdo_nxt    = r_shreg[LANE_W-1:0];
          w_shreg_nxt  = r_shreg >> LANE_W;
          w_sframe_nxt = 1'b1;
          w_beat_nxt   = r_beat + BEAT_W'(1);
        end
      end

      GAP: begin
        if (flush || (r_gap == '0)) begin
          w_state_nxt = IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_shreg_nxt = '0;
        w_beat_nxt  = '0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  assign word_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign sdo        = r_sdo;
  assign sframe     = r_sframe;
  assign done       = r_done;

endmodule
